// File: rtl/axis_pkt_arb_pkg.sv
// axis_pkt_arb_pkg: shared FSM state type and round-robin search helper for axis_pkt_rr_arb
package axis_pkt_arb_pkg;

    typedef enum logic {IDLE, PASS} arb_state_t;

    localparam int MAX_PORTS = 32;

    // First set bit of req found searching upward from ptr+1 with wrap at n.
    // Returns ptr unchanged when nothing requests.
    function automatic logic [31:0] rr_next(input logic [MAX_PORTS-1:0] req, input logic [31:0] ptr, input int n);
        logic [31:0] j;
        rr_next = ptr;
        // Walk distances from farthest to nearest so the nearest requester is written last.
        for (int k = MAX_PORTS; k >= 1; k--) begin
            if (k <= n) begin
                j = ptr + 32'(k);
                if (j >= 32'(n)) j = j - 32'(n);
                if (req[j[4:0]]) rr_next = j;
            end
        end
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// axis_rr_pick: combinational rotate-and-priority-encode of a request vector from a pointer
//   req  in   NUM_PORTS      request vector
//   ptr  in   NUM_PORTS_LOG  last granted index; search starts at ptr+1
//   idx  out  NUM_PORTS_LOG  chosen index (valid when any)
//   any  out  1              at least one request present
module axis_rr_pick
    import axis_pkt_arb_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int NUM_PORTS_LOG = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0]     req,
    input  logic [NUM_PORTS_LOG-1:0] ptr,
    output logic [NUM_PORTS_LOG-1:0] idx,
    output logic                     any
);

    if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
        $error("axis_rr_pick: NUM_PORTS must be in 2..32");
    end

    assign idx = NUM_PORTS_LOG'(rr_next(MAX_PORTS'(req), 32'(ptr), NUM_PORTS));
    assign any = |req;

endmodule

// File: rtl/axis_pkt_rr_arb.sv
// axis_pkt_rr_arb: packet-aware round-robin arbiter muxing NUM_PORTS AXI-Stream inputs onto one output
//   clk, aresetn              clock; asynchronous active-low reset
//   axis_in_*  [NUM_PORTS]    slave streams (tvalid/tready/tdata/tkeep/tlast/tuser/tid/tdest)
//   axis_out_*                master stream
//   port_en                   per-port arbitration enable, looked at only while idle
//   grant_valid, grant_idx    current grant holder
//   pkt_count                 packets forwarded per port; live only with AXIS_PKT_RR_ARB_STATS_EN
module axis_pkt_rr_arb
    import axis_pkt_arb_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int NUM_PORTS_LOG = $clog2(NUM_PORTS),
    parameter int CNT_WIDTH     = 32,
    parameter int DATA_BYTES    = 4,
    parameter int USER_WIDTH    = 1,
    parameter int ID_WIDTH      = 4,
    parameter int DEST_WIDTH    = 4
) (
    input  logic                                      clk,
    input  logic                                      aresetn,
    input  logic [NUM_PORTS-1:0]                      axis_in_tvalid,
    output logic [NUM_PORTS-1:0]                      axis_in_tready,
    input  logic [NUM_PORTS-1:0][DATA_BYTES*8-1:0]    axis_in_tdata,
    input  logic [NUM_PORTS-1:0][DATA_BYTES-1:0]      axis_in_tkeep,
    input  logic [NUM_PORTS-1:0]                      axis_in_tlast,
    input  logic [NUM_PORTS-1:0][USER_WIDTH-1:0]      axis_in_tuser,
    input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0]        axis_in_tid,
    input  logic [NUM_PORTS-1:0][DEST_WIDTH-1:0]      axis_in_tdest,
    output logic                                      axis_out_tvalid,
    input  logic                                      axis_out_tready,
    output logic [DATA_BYTES*8-1:0]                   axis_out_tdata,
    output logic [DATA_BYTES-1:0]                     axis_out_tkeep,
    output logic                                      axis_out_tlast,
    output logic [USER_WIDTH-1:0]                     axis_out_tuser,
    output logic [ID_WIDTH-1:0]                       axis_out_tid,
    output logic [DEST_WIDTH-1:0]                     axis_out_tdest,
    input  logic [NUM_PORTS-1:0]                      port_en,
    output logic                                      grant_valid,
    output logic [NUM_PORTS_LOG-1:0]                  grant_idx,
    output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]       pkt_count
);

    if (NUM_PORTS < 2) begin : g_bad_ports
        $error("axis_pkt_rr_arb: NUM_PORTS must be > 1");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt
        $error("axis_pkt_rr_arb: CNT_WIDTH must be > 0");
    end

    arb_state_t                 state_q, state_d;
    logic [NUM_PORTS_LOG-1:0]   grant_idx_q, grant_idx_d;
    logic [NUM_PORTS_LOG-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS_LOG-1:0]   pick_idx;
    logic [NUM_PORTS-1:0]       req;
    logic                       pick_any;
    logic                       pass;
    logic                       beat_done;

    assign req = axis_in_tvalid & port_en;

    axis_rr_pick #(
        .NUM_PORTS     (NUM_PORTS),
        .NUM_PORTS_LOG (NUM_PORTS_LOG)
    ) u_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        pass            = state_q == PASS;
        axis_out_tvalid = pass & axis_in_tvalid[grant_idx_q];
        axis_out_tdata  = axis_in_tdata[grant_idx_q];
        axis_out_tkeep  = axis_in_tkeep[grant_idx_q];
        axis_out_tlast  = axis_in_tlast[grant_idx_q];
        axis_out_tuser  = axis_in_tuser[grant_idx_q];
        axis_out_tid    = axis_in_tid[grant_idx_q];
        axis_out_tdest  = axis_in_tdest[grant_idx_q];
        axis_in_tready  = pass ? NUM_PORTS'(axis_out_tready) << grant_idx_q : '0;
        beat_done       = axis_out_tvalid & axis_out_tready & axis_out_tlast;
        // The grant is only released by an accepted tlast; idle sources and port_en are ignored meanwhile.
        state_d         = pass ? (beat_done ? IDLE : PASS) : (pick_any ? PASS : IDLE);
        grant_idx_d     = (!pass && pick_any) ? pick_idx : grant_idx_q;
        rr_ptr_d        = beat_done ? grant_idx_q : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= NUM_PORTS_LOG'(NUM_PORTS - 1);
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign grant_valid = pass;
    assign grant_idx   = grant_idx_q;

`ifdef AXIS_PKT_RR_ARB_STATS_EN
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

    always_comb begin
        pkt_count_d = pkt_count_q;
        if (beat_done) pkt_count_d[grant_idx_q] = pkt_count_q[grant_idx_q] + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) pkt_count_q <= '0;
        else          pkt_count_q <= pkt_count_d;
    end

    assign pkt_count = pkt_count_q;
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_axis_pkt_rr_arb.sv
// tb_axis_pkt_rr_arb: directed self-checking bench for axis_pkt_rr_arb
module tb_axis_pkt_rr_arb;

    localparam int N  = 4;
    localparam int CW = 32;
`ifdef AXIS_PKT_RR_ARB_STATS_EN
    localparam logic [31:0] CNT_EXP = 32'd4;
`else
    localparam logic [31:0] CNT_EXP = 32'd0;
`endif

    logic                 clk = 1'b0;
    logic                 aresetn;
    logic [N-1:0]         in_tvalid, in_tready, in_tlast;
    logic [N-1:0][31:0]   in_tdata;
    logic [N-1:0][3:0]    in_tkeep;
    logic [N-1:0][0:0]    in_tuser;
    logic [N-1:0][3:0]    in_tid, in_tdest;
    logic                 out_tvalid, out_tready, out_tlast;
    logic [31:0]          out_tdata;
    logic [3:0]           out_tkeep, out_tid, out_tdest;
    logic [0:0]           out_tuser;
    logic [N-1:0]         port_en;
    logic                 grant_valid;
    logic [1:0]           grant_idx;
    logic [N-1:0][CW-1:0] pkt_count;

    int           checks = 0;
    int           failures = 0;
    int           len[N];
    int           beat[N];
    int           npkt[N];
    logic [N-1:0] hold;

    always #5 clk = ~clk;

    axis_pkt_rr_arb dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .axis_in_tvalid  (in_tvalid),
        .axis_in_tready  (in_tready),
        .axis_in_tdata   (in_tdata),
        .axis_in_tkeep   (in_tkeep),
        .axis_in_tlast   (in_tlast),
        .axis_in_tuser   (in_tuser),
        .axis_in_tid     (in_tid),
        .axis_in_tdest   (in_tdest),
        .axis_out_tvalid (out_tvalid),
        .axis_out_tready (out_tready),
        .axis_out_tdata  (out_tdata),
        .axis_out_tkeep  (out_tkeep),
        .axis_out_tlast  (out_tlast),
        .axis_out_tuser  (out_tuser),
        .axis_out_tid    (out_tid),
        .axis_out_tdest  (out_tdest),
        .port_en         (port_en),
        .grant_valid     (grant_valid),
        .grant_idx       (grant_idx),
        .pkt_count       (pkt_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dat(input int p, input int b);
        return {8'(p), 8'(b), 16'hC0DE};
    endfunction

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            in_tvalid[p] = (npkt[p] > 0) && !hold[p];
            in_tdata[p]  = dat(p, beat[p]);
            in_tlast[p]  = beat[p] == len[p] - 1;
            in_tkeep[p]  = 4'hF;
            in_tuser[p]  = beat[p] == 0;
            in_tid[p]    = 4'(p);
            in_tdest[p]  = 4'(3 - p);
        end
    endtask

    // One clock: sources advance on the handshake seen just before the edge.
    task automatic step();
        logic [N-1:0] hs;
        hs = in_tvalid & in_tready;
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (hs[p]) begin
                if (beat[p] == len[p] - 1) begin
                    beat[p] = 0;
                    npkt[p]--;
                end else begin
                    beat[p]++;
                end
            end
        end
        drive();
        #1;
    endtask

    initial begin
        bit rdy[6] = '{1, 0, 0, 1, 1, 1};
        int eb[6]  = '{0, 1, 1, 1, 2, 3};
        int ord[6] = '{0, 1, 3, 0, 1, 3};
        aresetn    = 1'b0;
        port_en    = 4'hF;
        out_tready = 1'b1;
        hold       = '0;
        for (int p = 0; p < N; p++) begin
            len[p] = 1; beat[p] = 0; npkt[p] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("rst_out_tvalid", out_tvalid, 0);
        chk("rst_in_tready", in_tready, 0);
        chk("rst_pkt_count", pkt_count, 0);
        aresetn = 1'b1;
        #1;

        // All four ports offer a 3-beat packet at once.
        for (int p = 0; p < N; p++) begin
            len[p] = 3; npkt[p] = 1;
        end
        drive();
        #1;
        chk("t1_idle_tvalid", out_tvalid, 0);
        chk("t1_idle_tready", in_tready, 0);
        for (int p = 0; p < N; p++) begin
            step();
            chk("t1_grant_valid", grant_valid, 1);
            chk("t1_grant_idx", grant_idx, p);
            chk("t1_in_tready", in_tready, 4'b0001 << p);
            for (int b = 0; b < 3; b++) begin
                chk("t1_tvalid", out_tvalid, 1);
                chk("t1_tdata", out_tdata, dat(p, b));
                chk("t1_tlast", out_tlast, b == 2);
                chk("t1_tid", out_tid, p);
                chk("t1_tdest", out_tdest, 3 - p);
                step();
            end
            chk("t1_gap_grant_valid", grant_valid, 0);
            chk("t1_gap_tvalid", out_tvalid, 0);
        end

        // Port 2 alone, five single-beat packets.
        len[2] = 1; npkt[2] = 5;
        drive();
        #1;
        chk("t2_first_idle", out_tvalid, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_tvalid_hi", out_tvalid, 1);
            chk("t2_grant_idx", grant_idx, 2);
            chk("t2_tlast", out_tlast, 1);
            step();
            chk("t2_tvalid_lo", out_tvalid, 0);
        end

        // Port 1 stalls mid-packet with port 3 waiting; port_en drop for 1 is ignored.
        len[1] = 4; npkt[1] = 1;
        drive();
        #1;
        step();
        chk("t3_grant_idx", grant_idx, 1);
        chk("t3_beat0", out_tdata, dat(1, 0));
        step();
        hold[1] = 1'b1;
        port_en = 4'b1101;
        len[3]  = 2; npkt[3] = 1;
        drive();
        #1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_hold_grant_valid", grant_valid, 1);
            chk("t3_hold_grant_idx", grant_idx, 1);
            chk("t3_hold_tready3", in_tready[3], 0);
            chk("t3_hold_tvalid", out_tvalid, 0);
        end
        hold[1] = 1'b0;
        drive();
        #1;
        chk("t3_beat1", out_tdata, dat(1, 1));
        step();
        chk("t3_beat2", out_tdata, dat(1, 2));
        step();
        chk("t3_beat3", out_tdata, dat(1, 3));
        chk("t3_beat3_last", out_tlast, 1);
        step();
        chk("t3_release", grant_valid, 0);
        port_en = 4'hF;
        step();
        chk("t3_p3_grant", grant_idx, 3);
        chk("t3_p3_beat0", out_tdata, dat(3, 0));
        step();
        chk("t3_p3_beat1", out_tdata, dat(3, 1));
        step();
        chk("t3_p3_done", grant_valid, 0);

        // Output backpressure 1,0,0,1 during a 4-beat packet from port 0.
        len[0] = 4; npkt[0] = 1;
        drive();
        #1;
        step();
        chk("t4_grant_idx", grant_idx, 0);
        for (int i = 0; i < 6; i++) begin
            out_tready = rdy[i];
            #1;
            chk("t4_tvalid", out_tvalid, 1);
            chk("t4_tdata", out_tdata, dat(0, eb[i]));
            chk("t4_in_tready", in_tready, rdy[i] ? 4'b0001 : 4'b0000);
            step();
        end
        chk("t4_done", grant_valid, 0);
        out_tready = 1'b1;

        // Reset in the middle of a port 2 packet.
        len[2] = 4; npkt[2] = 1;
        drive();
        #1;
        step();
        chk("t6_grant_idx", grant_idx, 2);
        step();
        chk("t6_mid_tvalid", out_tvalid, 1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_async_grant_valid", grant_valid, 0);
        chk("t6_async_tvalid", out_tvalid, 0);
        chk("t6_async_tready", in_tready, 0);
        for (int p = 0; p < N; p++) begin
            npkt[p] = 0; beat[p] = 0;
        end
        drive();
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        #1;
        chk("t6_after_grant_idx", grant_idx, 0);
        chk("t6_after_pkt_count", pkt_count, 0);

        // port_en=1011 with everyone requesting: port 2 never wins.
        port_en = 4'b1011;
        for (int p = 0; p < N; p++) begin
            len[p] = 1; npkt[p] = 2;
        end
        drive();
        #1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_grant_valid", grant_valid, 1);
            chk("t5_grant_idx", grant_idx, ord[i]);
            chk("t5_in_tready", in_tready, 4'b0001 << ord[i]);
            step();
            chk("t5_gap", grant_valid, 0);
        end
        npkt[2] = 0;
        port_en = 4'hF;
        drive();
        #1;

        // Fresh reset, then four single-beat packets per port.
        aresetn = 1'b0;
        #3;
        aresetn = 1'b1;
        for (int p = 0; p < N; p++) begin
            len[p] = 1; npkt[p] = 4;
        end
        drive();
        #1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("t7_grant_idx", grant_idx, i % 4);
            step();
        end
        chk("t7_all_done", in_tvalid, 0);
        for (int p = 0; p < N; p++) chk("t7_pkt_count", pkt_count[p], CNT_EXP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
